// File: rtl/sram_core_ws_pkg.sv
// Shared definitions for the wait-state asynchronous SRAM controller.
package sram_core_ws_pkg;

  // Width of the wait-state down-counter (wait counts are 0..15).
  localparam int WAIT_W = 4;

  // Ceiling log2, usable in constant expressions.
  function automatic int clog2(input int value);
    int result;
    int v;
    result = 0;
    v = value - 1;
    while (v > 0) begin
      result = result + 1;
      v = v >> 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/sram_core_ws.sv
// Asynchronous-SRAM controller with programmable read/write wait states,
// byte-lane enables and incrementing bursts. All outputs are registered:
// each output flop is loaded from the value implied by the next state.
module sram_core_ws
  import sram_core_ws_pkg::*;
#(
  parameter int ADDR_BITS  = 22,
  parameter int DATA_BITS  = 32,
  parameter int READ_WAIT  = 1,
  parameter int WRITE_WAIT = 1,
  localparam int NB        = DATA_BITS / 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cs,
  input  logic                 we,
  input  logic [ADDR_BITS-3:0] addr,
  input  logic [NB-1:0]        sel,
  input  logic                 burst,
  input  logic [DATA_BITS-1:0] din,
  output logic [DATA_BITS-1:0] dout,
  output logic                 busy,
  output logic                 ack,
  output logic                 sram_ce_n,
  output logic                 sram_oe_n,
  output logic                 sram_we_n,
  output logic [NB-1:0]        sram_be_n,
  output logic [ADDR_BITS-3:0] sram_addr,
  input  logic [DATA_BITS-1:0] sram_din,
  output logic [DATA_BITS-1:0] sram_dout
);

  localparam int AW = ADDR_BITS - 2;

  // RWAIT lasts READ_WAIT cycles, WPULSE lasts WRITE_WAIT+1 cycles; both
  // leave when the counter reads zero.
  localparam logic [WAIT_W-1:0] RW_INIT = (READ_WAIT > 0) ? WAIT_W'(READ_WAIT - 1) : '0;
  localparam logic [WAIT_W-1:0] WW_INIT = WAIT_W'(WRITE_WAIT);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SETUP  = 3'd1,
    RWAIT  = 3'd2,
    READ   = 3'd3,
    WPULSE = 3'd4,
    WHOLD  = 3'd5
  } state_t;

  state_t              state_q, state_d;
  logic [WAIT_W-1:0]   cnt_q, cnt_d;
  logic                we_q, we_d;
  logic                busy_q, busy_d;
  logic                ack_q, ack_d;
  logic                ce_n_q, ce_n_d;
  logic                oe_n_q, oe_n_d;
  logic                we_n_q, we_n_d;
  logic [NB-1:0]       be_n_q, be_n_d;
  logic [AW-1:0]       addr_q, addr_d;
  logic [DATA_BITS-1:0] dout_q, dout_d;
  logic [DATA_BITS-1:0] wdata_q, wdata_d;
  logic                load;

  // Next-state, wait counter and registered-output values.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (cs) state_d = SETUP;
      end
      SETUP: begin
        if (we_q) begin
          state_d = WPULSE;
          cnt_d   = WW_INIT;
        end else if (READ_WAIT > 0) begin
          state_d = RWAIT;
          cnt_d   = RW_INIT;
        end else begin
          state_d = READ;
        end
      end
      RWAIT: begin
        if (cnt_q == '0) state_d = READ;
        else cnt_d = cnt_q - WAIT_W'(1);
      end
      WPULSE: begin
        if (cnt_q == '0) state_d = WHOLD;
        else cnt_d = cnt_q - WAIT_W'(1);
      end
      READ, WHOLD: begin
        if (cs && burst) state_d = SETUP;
        else state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // A beat's request fields are captured whenever SETUP is entered.
    load = (state_d == SETUP);
    we_d = load ? we : we_q;

    busy_d = (state_d != IDLE);
    ack_d  = (state_d == READ) || (state_d == WHOLD);
    ce_n_d = (state_d == IDLE);
    oe_n_d = !(((state_d == SETUP) || (state_d == RWAIT) || (state_d == READ)) && !we_d);
    we_n_d = (state_d != WPULSE);
    dout_d = (state_d == READ) ? sram_din : '0;

    addr_d  = addr_q;
    be_n_d  = be_n_q;
    wdata_d = wdata_q;
    if (state_d == IDLE) begin
      addr_d  = '0;
      be_n_d  = '1;
      wdata_d = '0;
    end else if (load) begin
      addr_d  = (state_q == IDLE) ? addr : addr_q + AW'(1);
      be_n_d  = ~sel;
      wdata_d = we ? din : '0;
    end
  end

  // State and output registers; reset forces strobes inactive at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      busy_q  <= 1'b0;
      ack_q   <= 1'b0;
      ce_n_q  <= 1'b1;
      oe_n_q  <= 1'b1;
      we_n_q  <= 1'b1;
      be_n_q  <= '1;
      addr_q  <= '0;
      dout_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      busy_q  <= busy_d;
      ack_q   <= ack_d;
      ce_n_q  <= ce_n_d;
      oe_n_q  <= oe_n_d;
      we_n_q  <= we_n_d;
      be_n_q  <= be_n_d;
      addr_q  <= addr_d;
      dout_q  <= dout_d;
      wdata_q <= wdata_d;
    end
  end

  assign dout      = dout_q;
  assign busy      = busy_q;
  assign ack       = ack_q;
  assign sram_ce_n = ce_n_q;
  assign sram_oe_n = oe_n_q;
  assign sram_we_n = we_n_q;
  assign sram_be_n = be_n_q;
  assign sram_addr = addr_q;
  assign sram_dout = wdata_q;

endmodule

// File: tb/tb_sram_core_ws.sv
// Directed bench for sram_core_ws: a 32-bit instance with READ_WAIT=2,
// WRITE_WAIT=1, 24-bit ADDR_BITS, and a 16-bit zero-wait instance.
module tb_sram_core_ws;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic        cs = 0, we = 0, burst = 0;
  logic [21:0] addr = '0;
  logic [3:0]  sel = '0;
  logic [31:0] din = '0, sram_din = '0;
  logic [31:0] dout, sram_dout;
  logic        busy, ack, ce_n, oe_n, we_n;
  logic [3:0]  be_n;
  logic [21:0] sram_addr;

  logic        h_cs = 0, h_we = 0, h_burst = 0;
  logic [19:0] h_addr = '0;
  logic [1:0]  h_sel = '0;
  logic [15:0] h_din = '0, h_sram_din = '0;
  logic [15:0] h_dout, h_sram_dout;
  logic        h_busy, h_ack, h_ce_n, h_oe_n, h_we_n;
  logic [1:0]  h_be_n;
  logic [19:0] h_sram_addr;

  int n_checks = 0;
  int n_fail   = 0;

  sram_core_ws #(.ADDR_BITS(24), .DATA_BITS(32), .READ_WAIT(2), .WRITE_WAIT(1)) dut (
    .clk(clk), .rst(rst), .cs(cs), .we(we), .addr(addr), .sel(sel), .burst(burst),
    .din(din), .dout(dout), .busy(busy), .ack(ack), .sram_ce_n(ce_n), .sram_oe_n(oe_n),
    .sram_we_n(we_n), .sram_be_n(be_n), .sram_addr(sram_addr), .sram_din(sram_din),
    .sram_dout(sram_dout)
  );

  sram_core_ws #(.ADDR_BITS(22), .DATA_BITS(16), .READ_WAIT(0), .WRITE_WAIT(0)) dut16 (
    .clk(clk), .rst(rst), .cs(h_cs), .we(h_we), .addr(h_addr), .sel(h_sel), .burst(h_burst),
    .din(h_din), .dout(h_dout), .busy(h_busy), .ack(h_ack), .sram_ce_n(h_ce_n),
    .sram_oe_n(h_oe_n), .sram_we_n(h_we_n), .sram_be_n(h_be_n), .sram_addr(h_sram_addr),
    .sram_din(h_sram_din), .sram_dout(h_sram_dout)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if ({busy, ack, ce_n, oe_n, we_n, be_n} !== 9'b0_0_111_1111) begin
      $display("FAIL reset_ctrl: got %b want %b", {busy, ack, ce_n, oe_n, we_n, be_n}, 9'b0_0_111_1111);
      n_fail++;
    end
    n_checks++;
    if ({sram_addr, dout, sram_dout} !== 86'd0) begin
      $display("FAIL reset_data: got addr %h dout %h sdout %h want 0", sram_addr, dout, sram_dout);
      n_fail++;
    end
    n_checks++;
    if ({h_busy, h_ack, h_ce_n, h_oe_n, h_we_n, h_be_n} !== 7'b0_0_111_11) begin
      $display("FAIL reset_narrow: got %b want %b", {h_busy, h_ack, h_ce_n, h_oe_n, h_we_n, h_be_n}, 7'b0011111);
      n_fail++;
    end
    @(negedge clk);
    rst = 1'b0;
    tick;
  endtask

  task automatic test_read;
    logic [31:0] exp_d;
    cs = 1; we = 0; addr = 22'h100; sel = 4'hF; burst = 0; sram_din = 32'hDEADBEEF;
    for (int c = 1; c <= 5; c++) begin
      tick;
      if (c == 1) cs = 0;
      n_checks++;
      if (oe_n !== ((c <= 4) ? 1'b0 : 1'b1)) begin
        $display("FAIL read_oe_n cycle %0d: got %b want %b", c, oe_n, (c <= 4) ? 1'b0 : 1'b1);
        n_fail++;
      end
      n_checks++;
      if (ack !== (c == 4)) begin
        $display("FAIL read_ack cycle %0d: got %b want %b", c, ack, (c == 4));
        n_fail++;
      end
      exp_d = (c == 4) ? 32'hDEADBEEF : 32'h0;
      n_checks++;
      if (dout !== exp_d) begin
        $display("FAIL read_dout cycle %0d: got %h want %h", c, dout, exp_d);
        n_fail++;
      end
      n_checks++;
      if (sram_addr !== ((c <= 4) ? 22'h100 : 22'h0)) begin
        $display("FAIL read_addr cycle %0d: got %h want %h", c, sram_addr, (c <= 4) ? 22'h100 : 22'h0);
        n_fail++;
      end
    end
  endtask

  task automatic test_write(input logic [3:0] s);
    logic [3:0]  exp_be;
    logic [31:0] exp_wd;
    logic [21:0] exp_a;
    cs = 1; we = 1; addr = 22'h2A5; sel = s; burst = 0; din = 32'h12345678;
    for (int c = 1; c <= 5; c++) begin
      tick;
      if (c == 1) begin cs = 0; din = 32'h0; sel = 4'h0; end
      n_checks++;
      if (we_n !== ((c == 2 || c == 3) ? 1'b0 : 1'b1)) begin
        $display("FAIL write_we_n sel=%b cycle %0d: got %b want %b", s, c, we_n, (c == 2 || c == 3) ? 1'b0 : 1'b1);
        n_fail++;
      end
      n_checks++;
      if (ack !== (c == 4)) begin
        $display("FAIL write_ack sel=%b cycle %0d: got %b want %b", s, c, ack, (c == 4));
        n_fail++;
      end
      exp_be = (c <= 4) ? ~s : 4'hF;
      n_checks++;
      if (be_n !== exp_be) begin
        $display("FAIL write_be_n sel=%b cycle %0d: got %b want %b", s, c, be_n, exp_be);
        n_fail++;
      end
      exp_a = (c <= 4) ? 22'h2A5 : 22'h0;
      exp_wd = (c <= 4) ? 32'h12345678 : 32'h0;
      n_checks++;
      if (sram_addr !== exp_a || sram_dout !== exp_wd || oe_n !== 1'b1) begin
        $display("FAIL write_bus sel=%b cycle %0d: got addr %h data %h oe_n %b want %h %h 1",
                 s, c, sram_addr, sram_dout, oe_n, exp_a, exp_wd);
        n_fail++;
      end
    end
  endtask

  task automatic test_burst_wrap;
    logic [21:0] exp_a;
    logic [31:0] exp_d;
    logic        exp_ack;
    int          beat;
    int          acks;
    acks = 0;
    cs = 1; we = 0; addr = 22'h3FFFFE; sel = 4'hF; burst = 1; sram_din = 32'hA0000000;
    for (int c = 1; c <= 17; c++) begin
      tick;
      sram_din = 32'hA0000000 | c;
      burst = (c < 13);
      cs = (c < 13);
      beat = (c - 1) / 4;
      exp_a = 22'h3FFFFE;
      exp_a = exp_a + beat[21:0];
      if (c == 17) exp_a = 22'h0;
      exp_ack = ((c % 4) == 0) && (c <= 16);
      exp_d = exp_ack ? (32'hA0000000 | (c - 1)) : 32'h0;
      if (ack) acks++;
      n_checks++;
      if (sram_addr !== exp_a) begin
        $display("FAIL burst_addr cycle %0d: got %h want %h", c, sram_addr, exp_a);
        n_fail++;
      end
      n_checks++;
      if (ack !== exp_ack || dout !== exp_d) begin
        $display("FAIL burst_ack cycle %0d: got ack %b dout %h want %b %h", c, ack, dout, exp_ack, exp_d);
        n_fail++;
      end
    end
    n_checks++;
    if (acks != 4 || busy !== 1'b0) begin
      $display("FAIL burst_count: got %0d acks busy %b want 4 acks busy 0", acks, busy);
      n_fail++;
    end
  endtask

  task automatic test_mixed;
    logic [21:0] exp_a;
    logic        exp_oe, exp_we, exp_ack;
    logic [31:0] exp_wd;
    cs = 1; we = 0; addr = 22'h50; sel = 4'hF; burst = 1; din = 32'hCAFE0001;
    for (int c = 1; c <= 13; c++) begin
      tick;
      we = (c >= 4 && c < 8);
      burst = (c < 12);
      cs = (c < 12);
      exp_a  = (c <= 4) ? 22'h50 : (c <= 8) ? 22'h51 : (c <= 12) ? 22'h52 : 22'h0;
      exp_oe = !((c <= 4) || (c >= 9 && c <= 12));
      exp_we = !(c == 6 || c == 7);
      exp_ack = (c == 4 || c == 8 || c == 12);
      exp_wd = (c >= 5 && c <= 8) ? 32'hCAFE0001 : 32'h0;
      n_checks++;
      if (oe_n === 1'b0 && we_n === 1'b0) begin
        $display("FAIL mixed_overlap cycle %0d: got oe_n %b we_n %b want not both 0", c, oe_n, we_n);
        n_fail++;
      end
      n_checks++;
      if (oe_n !== exp_oe || we_n !== exp_we) begin
        $display("FAIL mixed_strobes cycle %0d: got oe_n %b we_n %b want %b %b", c, oe_n, we_n, exp_oe, exp_we);
        n_fail++;
      end
      n_checks++;
      if (ack !== exp_ack || sram_addr !== exp_a || sram_dout !== exp_wd) begin
        $display("FAIL mixed_beat cycle %0d: got ack %b addr %h data %h want %b %h %h",
                 c, ack, sram_addr, sram_dout, exp_ack, exp_a, exp_wd);
        n_fail++;
      end
    end
  endtask

  task automatic test_reset_mid;
    cs = 1; we = 1; addr = 22'h77; sel = 4'hF; burst = 0; din = 32'h55AA55AA;
    tick;
    cs = 0;
    tick;
    n_checks++;
    if (we_n !== 1'b0) begin
      $display("FAIL rstmid_pre: got we_n %b want 0", we_n);
      n_fail++;
    end
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if ({we_n, ce_n, busy, ack, be_n} !== 8'b1100_1111) begin
      $display("FAIL rstmid_async: got %b want %b", {we_n, ce_n, busy, ack, be_n}, 8'b11001111);
      n_fail++;
    end
    @(negedge clk);
    rst = 1'b0;
    tick;
    for (int c = 0; c < 4; c++) begin
      n_checks++;
      if (ack !== 1'b0 || busy !== 1'b0 || ce_n !== 1'b1) begin
        $display("FAIL rstmid_idle step %0d: got ack %b busy %b ce_n %b want 0 0 1", c, ack, busy, ce_n);
        n_fail++;
      end
      tick;
    end
    cs = 1; we = 0; addr = 22'h33; sram_din = 32'h01020304;
    for (int c = 1; c <= 5; c++) begin
      tick;
      if (c == 1) cs = 0;
      n_checks++;
      if (ack !== (c == 4) || dout !== ((c == 4) ? 32'h01020304 : 32'h0)) begin
        $display("FAIL rstmid_after cycle %0d: got ack %b dout %h want %b %h",
                 c, ack, dout, (c == 4), (c == 4) ? 32'h01020304 : 32'h0);
        n_fail++;
      end
    end
  endtask

  task automatic test_narrow;
    h_cs = 1; h_we = 0; h_addr = 20'h1234; h_sel = 2'b11; h_sram_din = 16'hBEEF;
    for (int c = 1; c <= 3; c++) begin
      tick;
      if (c == 1) h_cs = 0;
      n_checks++;
      if (h_oe_n !== (c > 2) || h_ack !== (c == 2) || h_dout !== ((c == 2) ? 16'hBEEF : 16'h0)) begin
        $display("FAIL narrow_read cycle %0d: got oe_n %b ack %b dout %h want %b %b %h",
                 c, h_oe_n, h_ack, h_dout, (c > 2), (c == 2), (c == 2) ? 16'hBEEF : 16'h0);
        n_fail++;
      end
      n_checks++;
      if (h_sram_addr !== ((c <= 2) ? 20'h1234 : 20'h0) || h_busy !== (c <= 2) || h_ce_n !== (c > 2)) begin
        $display("FAIL narrow_rctl cycle %0d: got addr %h busy %b ce_n %b", c, h_sram_addr, h_busy, h_ce_n);
        n_fail++;
      end
    end
    h_cs = 1; h_we = 1; h_sel = 2'b10; h_din = 16'h5A5A;
    for (int c = 1; c <= 4; c++) begin
      tick;
      if (c == 1) h_cs = 0;
      n_checks++;
      if (h_we_n !== (c != 2) || h_ack !== (c == 3)) begin
        $display("FAIL narrow_write cycle %0d: got we_n %b ack %b want %b %b", c, h_we_n, h_ack, (c != 2), (c == 3));
        n_fail++;
      end
      n_checks++;
      if (h_be_n !== ((c <= 3) ? 2'b01 : 2'b11) || h_sram_dout !== ((c <= 3) ? 16'h5A5A : 16'h0)) begin
        $display("FAIL narrow_wbus cycle %0d: got be_n %b data %h want %b %h",
                 c, h_be_n, h_sram_dout, (c <= 3) ? 2'b01 : 2'b11, (c <= 3) ? 16'h5A5A : 16'h0);
        n_fail++;
      end
    end
  endtask

  initial begin
    test_reset;
    test_read;
    test_write(4'b0101);
    test_write(4'b0000);
    test_burst_wrap;
    test_mixed;
    test_reset_mid;
    test_narrow;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
